// File: rtl/reg_bus_pkg.sv
// Shared definitions for the register-bus initiator: the FSM encoding and the
// width helper for the optional wait counter.
package reg_bus_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    WAIT  = ST_WAIT,
    RESP  = ST_RESP
  } state_e;

  // The counter must be able to represent the full TimeoutCycles value.
  function automatic int unsigned wd_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/reg_bus_initiator_if.sv
// Port bundle for reg_bus_initiator: command port, response port, bus port and
// status. The master modport is the initiator's view, slave the environment's.
interface reg_bus_initiator_if #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 32
);
  localparam int unsigned BeWidth = DataWidth / 8;

  // cmd and rsp are valid/ready: a beat transfers on a rising clock edge where
  // valid and ready are both high; a valid beat holds its payload until then.
  logic                    cmd_valid_i;
  logic                    cmd_ready_o;
  logic [AddressWidth-1:0] cmd_addr_i;
  logic                    cmd_we_i;
  logic [BeWidth-1:0]      cmd_be_i;
  logic [DataWidth-1:0]    cmd_wdata_i;

  logic                    rsp_valid_o;
  logic                    rsp_ready_i;
  logic [DataWidth-1:0]    rsp_rdata_o;
  logic                    rsp_err_o;
  logic                    rsp_timeout_o;

  logic                    bus_req_o;
  logic [AddressWidth-1:0] bus_addr_o;
  logic                    bus_we_o;
  logic [BeWidth-1:0]      bus_be_o;
  logic [DataWidth-1:0]    bus_wdata_o;
  logic                    bus_rvalid_i;
  logic [DataWidth-1:0]    bus_rdata_i;
  logic                    bus_err_i;

  logic                    busy_o;
  logic [1:0]              dbg_state_o;

  modport master (
    input  cmd_valid_i, cmd_addr_i, cmd_we_i, cmd_be_i, cmd_wdata_i,
    input  rsp_ready_i,
    input  bus_rvalid_i, bus_rdata_i, bus_err_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
    output bus_req_o, bus_addr_o, bus_we_o, bus_be_o, bus_wdata_o,
    output busy_o, dbg_state_o
  );

  modport slave (
    output cmd_valid_i, cmd_addr_i, cmd_we_i, cmd_be_i, cmd_wdata_i,
    output rsp_ready_i,
    output bus_rvalid_i, bus_rdata_i, bus_err_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
    input  bus_req_o, bus_addr_o, bus_we_o, bus_be_o, bus_wdata_o,
    input  busy_o, dbg_state_o
  );

endinterface

// File: rtl/reg_bus_watchdog.sv
// Wait-cycle counter for reg_bus_initiator: cleared while issuing, counts WAIT
// cycles, flags expiry during the last permitted WAIT cycle.
module reg_bus_watchdog
  import reg_bus_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_o
);

  localparam int unsigned CntWidth = wd_width(TimeoutCycles);
  localparam logic [CntWidth-1:0] LastCnt = CntWidth'(TimeoutCycles - 1);

  logic [CntWidth-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of WAIT cycles already elapsed before this one.
  assign expired_o = count_i && (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_i && !expired_o) begin
      cnt_d = cnt_q + CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/reg_bus_initiator.sv
// Single-outstanding register-bus initiator: IDLE -> ISSUE -> WAIT -> RESP.
// Define REG_BUS_INITIATOR_TIMEOUT_EN to build the WAIT-state watchdog.
module reg_bus_initiator
  import reg_bus_pkg::*;
#(
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned AddressWidth  = 32,
  parameter int unsigned TimeoutCycles = 16
) (
  input logic                 clk_i,
  input logic                 rst_i,
  reg_bus_initiator_if.master bus_if
);

  localparam int unsigned BeWidth = DataWidth / 8;

  typedef struct packed {
    logic [AddressWidth-1:0] addr;
    logic                    we;
    logic [BeWidth-1:0]      be;
    logic [DataWidth-1:0]    wdata;
  } cmd_t;

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic                 err;
    logic                 timeout;
  } rsp_t;

  if (TimeoutCycles < 2) begin : g_bad_timeout
    $error("reg_bus_initiator: TimeoutCycles must be at least 2");
  end

  logic [1:0] state_q, state_d;
  cmd_t       cmd_q, cmd_d;
  rsp_t       rsp_q, rsp_d;
  logic       wd_expired;

`ifdef REG_BUS_INITIATOR_TIMEOUT_EN
  reg_bus_watchdog #(
    .TimeoutCycles(TimeoutCycles)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (state_q == ST_ISSUE),
    .count_i   (state_q == ST_WAIT),
    .expired_o (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  // A real response in the final WAIT cycle takes priority over expiry.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    rsp_d   = rsp_q;
    case (state_q)
      ST_IDLE: begin
        if (bus_if.cmd_valid_i) begin
          cmd_d.addr  = bus_if.cmd_addr_i;
          cmd_d.we    = bus_if.cmd_we_i;
          cmd_d.be    = bus_if.cmd_be_i;
          cmd_d.wdata = bus_if.cmd_wdata_i;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus_if.bus_rvalid_i) begin
          rsp_d.rdata   = bus_if.bus_rdata_i;
          rsp_d.err     = bus_if.bus_err_i;
          rsp_d.timeout = 1'b0;
          state_d       = ST_RESP;
        end else if (wd_expired) begin
          rsp_d.rdata   = '0;
          rsp_d.err     = 1'b1;
          rsp_d.timeout = 1'b1;
          state_d       = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus_if.rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      rsp_q   <= rsp_d;
    end
  end

  // Handshake and strobe outputs decode the state alone, so reset drops them at once.
  assign bus_if.cmd_ready_o   = (state_q == ST_IDLE);
  assign bus_if.bus_req_o     = (state_q == ST_ISSUE);
  assign bus_if.rsp_valid_o   = (state_q == ST_RESP);
  assign bus_if.busy_o        = (state_q != ST_IDLE);
  assign bus_if.dbg_state_o   = state_q;

  assign bus_if.bus_addr_o    = cmd_q.addr;
  assign bus_if.bus_we_o      = cmd_q.we;
  assign bus_if.bus_be_o      = cmd_q.be;
  assign bus_if.bus_wdata_o   = cmd_q.wdata;

  assign bus_if.rsp_rdata_o   = rsp_q.rdata;
  assign bus_if.rsp_err_o     = rsp_q.err;
  assign bus_if.rsp_timeout_o = rsp_q.timeout;

endmodule

// File: tb/tb_reg_bus_initiator.sv
// Directed bench for reg_bus_initiator with a registered responder model and a
// queue-based response scoreboard.
module tb_reg_bus_initiator;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks   = 0;
  int failures = 0;

  logic [33:0] exp_q[$];

  // Responder model controls.
  int          resp_cnt     = 0;
  int          resp_delay   = 1;
  bit          silent       = 1'b0;
  bit          inject_stray = 1'b0;
  logic [31:0] resp_addr    = '0;
  logic        resp_we      = 1'b0;

  reg_bus_initiator_if #(.DataWidth(32), .AddressWidth(32)) bif ();

  reg_bus_initiator #(
    .DataWidth     (32),
    .AddressWidth  (32),
    .TimeoutCycles (16)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_if (bif)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Registered responder: answers a request seen in cycle k during cycle k+resp_delay.
  initial begin
    bif.bus_rvalid_i = 1'b0;
    bif.bus_rdata_i  = '0;
    bif.bus_err_i    = 1'b0;
    forever begin
      tick();
      bif.bus_rvalid_i = 1'b0;
      bif.bus_rdata_i  = '0;
      bif.bus_err_i    = 1'b0;
      if (resp_cnt == 1) begin
        bif.bus_rvalid_i = 1'b1;
        if (resp_we) bif.bus_rdata_i = 32'h0000_5A5A;
        else if (resp_addr == 32'h4) bif.bus_rdata_i = 32'hDEAD_BEEF;
        else bif.bus_rdata_i = {16'hC0DE, resp_addr[15:0]};
        bif.bus_err_i = (resp_addr == 32'h10);
      end else if (inject_stray) begin
        bif.bus_rvalid_i = 1'b1;
        bif.bus_rdata_i  = 32'hBADB_AD00;
        bif.bus_err_i    = 1'b1;
        inject_stray     = 1'b0;
      end
      if (resp_cnt > 0) resp_cnt--;
      if (bif.bus_req_o && !silent) begin
        resp_cnt  = resp_delay;
        resp_addr = bif.bus_addr_o;
        resp_we   = bif.bus_we_o;
      end
    end
  end

  // Scoreboard monitor: every response handshake must match the queue head.
  initial begin
    logic [33:0] e;
    forever begin
      @(negedge clk);
      if (bif.rsp_valid_o && bif.rsp_ready_i) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 64'(bif.rsp_rdata_o), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("sb_rdata", 64'(bif.rsp_rdata_o), 64'(e[33:2]));
          check("sb_err", 64'(bif.rsp_err_o), 64'(e[1]));
          check("sb_timeout", 64'(bif.rsp_timeout_o), 64'(e[0]));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL sim_time_limit actual=running required=finished");
    $fatal(1, "time limit");
  end

  // Issues one command, checks the ISSUE cycle, returns the cycle rsp_valid_o rose.
  task automatic run_cmd(input logic [31:0] a, input logic we, input logic [3:0] be,
                         input logic [31:0] wd, input logic [31:0] exp_rdata,
                         input logic exp_err, input logic exp_to, output int rsp_cyc);
    int  n;
    bit  extra_req;
    bif.cmd_addr_i  = a;
    bif.cmd_we_i    = we;
    bif.cmd_be_i    = be;
    bif.cmd_wdata_i = wd;
    bif.cmd_valid_i = 1'b1;
    n = 0;
    while (!bif.cmd_ready_o && n < 50) begin
      tick();
      n++;
    end
    check("cmd_accept", 64'(bif.cmd_ready_o), 64'd1);
    exp_q.push_back({exp_rdata, exp_err, exp_to});
    tick();
    bif.cmd_valid_i = 1'b0;
    check("issue_req", 64'(bif.bus_req_o), 64'd1);
    check("issue_fields", {bif.bus_addr_o, bif.bus_we_o, bif.bus_be_o, 27'd0},
          {a, we, be, 27'd0});
    check("issue_wdata", 64'(bif.bus_wdata_o), 64'(wd));
    rsp_cyc   = 1;
    extra_req = 1'b0;
    while (!bif.rsp_valid_o && rsp_cyc < 100) begin
      tick();
      rsp_cyc++;
      if (bif.bus_req_o) extra_req = 1'b1;
    end
    check("req_once", 64'(extra_req), 64'd0);
    check("rsp_seen", 64'(bif.rsp_valid_o), 64'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bif.busy_o && n < 200) begin
      tick();
      n++;
    end
    check("idle_reached", 64'(bif.busy_o), 64'd0);
  endtask

  initial begin
    int c;
    bif.cmd_valid_i = 1'b0;
    bif.cmd_addr_i  = '0;
    bif.cmd_we_i    = 1'b0;
    bif.cmd_be_i    = '0;
    bif.cmd_wdata_i = '0;
    bif.rsp_ready_i = 1'b1;
    repeat (3) tick();

    // Reset state.
    check("rst_cmd_ready", 64'(bif.cmd_ready_o), 64'd1);
    check("rst_ctrl", {bif.bus_req_o, bif.rsp_valid_o, bif.rsp_err_o, bif.rsp_timeout_o,
                       bif.busy_o, bif.bus_we_o, bif.bus_be_o}, 64'd0);
    check("rst_data", {bif.bus_addr_o, bif.bus_wdata_o}, 64'd0);
    check("rst_rdata", 64'(bif.rsp_rdata_o), 64'd0);
    rst = 1'b0;
    tick();

    // Read with a one-cycle responder.
    run_cmd(32'h4, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, c);
    check("read_rsp_cycle", 64'(c), 64'd3);
    check("read_rdata", 64'(bif.rsp_rdata_o), 64'hDEAD_BEEF);
    check("read_err", 64'(bif.rsp_err_o), 64'd0);
    tick();
    check("read_cycle4_ready", {bif.cmd_ready_o, bif.busy_o}, 64'b10);

    // Write with partial strobes.
    run_cmd(32'h8, 1'b1, 4'b0011, 32'h1234_5678, 32'h0000_5A5A, 1'b0, 1'b0, c);
    check("write_rsp_cycle", 64'(c), 64'd3);
    wait_idle();

    // Bus error.
    run_cmd(32'h10, 1'b0, 4'hF, 32'h0, 32'hC0DE_0010, 1'b1, 1'b0, c);
    check("err_flags", {bif.rsp_err_o, bif.rsp_timeout_o}, 64'b10);
    wait_idle();

    // Backpressure with a pending command.
    bif.rsp_ready_i = 1'b0;
    run_cmd(32'h20, 1'b0, 4'hF, 32'h0, 32'hC0DE_0020, 1'b0, 1'b0, c);
    check("bp_rsp_cycle", 64'(c), 64'd3);
    bif.cmd_addr_i  = 32'h24;
    bif.cmd_we_i    = 1'b0;
    bif.cmd_valid_i = 1'b1;
    exp_q.push_back({32'hC0DE_0024, 1'b0, 1'b0});
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", {bif.rsp_valid_o, bif.rsp_rdata_o, bif.rsp_err_o, bif.rsp_timeout_o,
                        bif.cmd_ready_o, bif.bus_req_o}, {27'd0, 1'b1, 32'hC0DE_0020, 4'b0000});
      tick();
    end
    bif.rsp_ready_i = 1'b1;
    tick();
    check("bp_after_hs", {bif.cmd_ready_o, bif.bus_req_o, bif.rsp_valid_o}, 64'b100);
    tick();
    bif.cmd_valid_i = 1'b0;
    check("bp_next_issue", {bif.bus_req_o, bif.bus_addr_o}, {31'd0, 1'b1, 32'h24});
    wait_idle();

    // Real response in the last permitted WAIT cycle.
    resp_delay = 16;
    run_cmd(32'h44, 1'b0, 4'hF, 32'h0, 32'hC0DE_0044, 1'b0, 1'b0, c);
    check("late_ok_cycle", 64'(c), 64'd18);
    check("late_ok_flags", {bif.rsp_err_o, bif.rsp_timeout_o}, 64'b00);
    wait_idle();
    resp_delay = 1;

`ifdef REG_BUS_INITIATOR_TIMEOUT_EN
    // Silent responder: watchdog answers.
    silent = 1'b1;
    run_cmd(32'h40, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1, 1'b1, c);
    check("timeout_cycle", 64'(c), 64'd18);
    check("timeout_rsp", {bif.rsp_rdata_o, bif.rsp_err_o, bif.rsp_timeout_o}, {32'h0, 2'b11});
    wait_idle();
    silent = 1'b0;
`else
    // Without the watchdog a slow responder is simply waited for.
    resp_delay = 30;
    run_cmd(32'h40, 1'b0, 4'hF, 32'h0, 32'hC0DE_0040, 1'b0, 1'b0, c);
    check("slow_rsp_cycle", 64'(c), 64'd32);
    check("slow_rsp_flags", {bif.rsp_err_o, bif.rsp_timeout_o}, 64'b00);
    wait_idle();
    resp_delay = 1;
`endif

    // Stray rvalid in IDLE is dropped.
    inject_stray = 1'b1;
    tick();
    tick();
    tick();
    check("stray_ignored", {bif.busy_o, bif.rsp_valid_o}, 64'b00);
    run_cmd(32'h4, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, c);
    check("post_stray_rdata", 64'(bif.rsp_rdata_o), 64'hDEAD_BEEF);
    wait_idle();

    // Reset while in WAIT drops the transaction.
    silent          = 1'b1;
    bif.cmd_addr_i  = 32'h50;
    bif.cmd_we_i    = 1'b0;
    bif.cmd_valid_i = 1'b1;
    tick();
    bif.cmd_valid_i = 1'b0;
    tick();
    tick();
    check("pre_rst_wait", 64'(bif.dbg_state_o), 64'd2);
    rst = 1'b1;
    #1;
    check("rst_async", {bif.bus_req_o, bif.rsp_valid_o, bif.busy_o}, 64'b000);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_release", {bif.cmd_ready_o, bif.busy_o}, 64'b10);
    check("rst_addr_cleared", 64'(bif.bus_addr_o), 64'd0);
    silent = 1'b0;
    tick();
    run_cmd(32'h4, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, c);
    check("post_rst_cycle", 64'(c), 64'd3);
    wait_idle();

    repeat (3) tick();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
